alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational 64-bit `alu` between two requesters: the execute stage's OPq path (port 0) and the address/stack-pointer calculation path (port 1). It arbitrates between them round-robin with valid/ready handshakes and registers each result in a one-entry response buffer. It also owns the architectural condition-code register (ZF, SF, OF), which it updates only for port-0 operations that request it.

## Interface
Parameters:
- `W`, 64: operand and result width; must match `alu`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req0_valid`  in  1  port 0 (execute) request present.
- `req0_ready`  out  1  port 0 request accepted this cycle.
- `req0_ctrl`  in  2  ALU op: 00 add, 01 sub, 10 and, 11 xor.
- `req0_a`, `req0_b`  in  W  operands.
- `req0_set_cc`  in  1  update CC with this result.
- `req1_valid`, `req1_ready`, `req1_ctrl`, `req1_a`, `req1_b`  same as port 0; port 1 never updates CC.
- `rsp_valid`  out  1  response buffer holds a result.
- `rsp_ready`  in  1  consumer takes the result this cycle.
- `rsp_id`  out  1  requester that owns the result (0 or 1).
- `rsp_data`  out  W  ALU result.
- `rsp_ovf`  out  1  ALU signed overflow (0 for and/xor).
- `cc_zf`, `cc_sf`, `cc_of`  out  1 each  condition codes.

## Operation
- **Accept condition:** `can_accept = !rsp_valid || rsp_ready`. The arbiter grants at most one request per cycle, and only when `can_accept` is high.
- **Arbitration:** round-robin on a 1-bit `last` pointer.
  - If both valid, grant the port ≠ `last`.
  - If one valid, grant it.
  - `last` updates to the granted port on every accept.
  - Reset value of `last` is 1, so port 0 wins the first tie.
- **Ready outputs:** `reqN_ready` = grant to N. Both are 0 when `can_accept` is 0. Each ready depends combinationally on both valids and on `rsp_ready`.
- **Request stability:** a requester holds valid and payload stable until ready. The block does not re-check stability.
- **Datapath:** the granted port's ctrl, a and b are muxed into `alu`.
  - On the accept edge, capture `rsp_data`, `rsp_ovf`, `rsp_id`, and set `rsp_valid` = 1.
  - Sub is a − b. Callers order operands accordingly.
- **Response drain:** `rsp_valid` clears on `rsp_ready` when nothing is accepted that cycle. When drain and accept happen in the same cycle, the buffer is overwritten and `rsp_valid` stays 1.
- **Condition codes:** on the accept edge of a port-0 request with `req0_set_cc` = 1:
  - ZF = (result == 0)
  - SF = result[W−1]
  - OF = ALU overflow
  - All other cycles hold CC.
- **Output reset values:** `rsp_valid` 0, `rsp_id` 0, `rsp_data` 0, `rsp_ovf` 0, ZF 1, SF 0, OF 0.
- **Reset mid-operation:** reset discards any buffered response. No partial CC update occurs.

## Timing
- Latency is one cycle: a request accepted at edge k has its result visible on `rsp_*` after edge k.
- CC becomes visible at the same edge as the result.
- Throughput is one op per cycle while `rsp_ready` = 1 every cycle.
- With both ports continuously valid, grants strictly alternate 0,1,0,1.
- Backpressure: with `rsp_valid`=1 and `rsp_ready`=0, both readies are 0 and the buffer and CC hold.
- Combinational path: `reqN_valid` / `rsp_ready` → grant → ALU → capture register. This fits within the one-cycle budget set for the execute stage.

## Structure
- **Shared package `alu_pkg`:**
  - ALU op constants `ALU_ADD`=2'b00, `ALU_SUB`=2'b01, `ALU_AND`=2'b10, `ALU_XOR`=2'b11.
  - Requester ids `REQ_EXE`=0, `REQ_ADDR`=1.
  - Widths `W`=64.
- **Sub-modules:**
  - Instantiate the existing `alu` unchanged.
  - Put the 2-way round-robin grant logic in one sub-module, `rr_arb2` (inputs: valid[1:0], en, last; outputs: grant[1:0]).
- Response buffer, CC register and `last` pointer stay in the top module.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles, then release → `rsp_valid`=0, ZF=1, SF=0, OF=0, both readies 0 with no valid.
- **Port-0 add with CC:** a=5, b=−5, ctrl 00, set_cc=1 → next cycle `rsp_data`=0, `rsp_id`=0, ZF=1, SF=0, OF=0.
- **Sub overflow:** a=0x8000_0000_0000_0000, b=1, ctrl 01, set_cc=1 → `rsp_data`=0x7FFF_FFFF_FFFF_FFFF, `rsp_ovf`=1, OF=1, SF=0, ZF=0.
- **Contention:** both ports valid for 4 cycles with `rsp_ready`=1. Port 0 is and 0xF0 & 0x3C; port 1 is add 8+16 → grants 0,1,0,1; results 0x30, 24, 0x30, 24. CC changes only on port-0 accepts.
- **Port-1 isolation:** a port-1 xor 7^7 = 0 → `rsp_data`=0, `rsp_id`=1, CC unchanged from the previous port-0 value.
- **Backpressure and reset:**
  - Buffer full, `rsp_ready`=0 for 3 cycles → readies stay 0 and `rsp_data` is held.
  - Then drain plus a new accept in the same cycle → `rsp_valid` stays 1 with the new data.
  - Then assert `rst_n`=0 while valid → `rsp_valid`=0 on the next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU and its arbiter.
// Defines op codes, requester ids and the datapath width.
package alu_pkg;

    localparam int W = 64;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    localparam logic REQ_EXE  = 1'b0;
    localparam logic REQ_ADDR = 1'b1;

endpackage

// File: rtl/alu.sv
// Combinational W-bit ALU: add, sub (a - b), and, xor.
// Ports: ctrl (op), a, b (operands), result, ovf (signed overflow).
module alu #(
    parameter int W = alu_pkg::W
) (
    input  logic [1:0]   ctrl,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         ovf
);
    import alu_pkg::*;

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        unique case (ctrl)
            ALU_ADD: begin
                result = a + b;
                // Same-signed operands giving an opposite-signed sum.
                ovf = (a[W-1] == b[W-1]) &&
                      (result[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                result = a - b;
                // Opposite-signed operands and the sign flipped from a.
                ovf = (a[W-1] != b[W-1]) &&
                      (result[W-1] != a[W-1]);
            end
            ALU_AND: result = a & b;
            ALU_XOR: result = a ^ b;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the port other than last wins a tie.
// Ports: valid[1:0], en (may grant), last (previous winner), grant[1:0].
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       en,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant    = 2'b00;
        grant[0] = en && valid[0] && (!valid[1] || last);
        grant[1] = en && valid[1] && (!valid[0] || !last);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with a one-entry response buffer.
// Ports: clk, rst_n (sync, active-low), req0_*/req1_* valid/ready requests,
// rsp_* valid/ready response, cc_zf/cc_sf/cc_of condition codes.
module alu_arbiter #(
    parameter int W = alu_pkg::W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_ctrl,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_set_cc,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_ctrl,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_data,
    output logic         rsp_ovf,
    output logic         cc_zf,
    output logic         cc_sf,
    output logic         cc_of
);
    import alu_pkg::*;

    logic         can_accept;
    logic         last;
    logic [1:0]   grant;
    logic [1:0]   alu_ctrl;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_result;
    logic         alu_ovf;

    // The buffer frees up in the same cycle it is drained.
    assign can_accept = !rsp_valid || rsp_ready;

    rr_arb2 u_arb (
        .valid ({req1_valid, req0_valid}),
        .en    (can_accept),
        .last  (last),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        alu_ctrl = req0_ctrl;
        alu_a    = req0_a;
        alu_b    = req0_b;
        if (grant[1]) begin
            alu_ctrl = req1_ctrl;
            alu_a    = req1_a;
            alu_b    = req1_b;
        end
    end

    alu #(.W(W)) u_alu (
        .ctrl   (alu_ctrl),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= REQ_EXE;
            rsp_data  <= '0;
            rsp_ovf   <= 1'b0;
            cc_zf     <= 1'b1;
            cc_sf     <= 1'b0;
            cc_of     <= 1'b0;
            last      <= REQ_ADDR;
        end else if (|grant) begin
            rsp_valid <= 1'b1;
            rsp_id    <= grant[1] ? REQ_ADDR : REQ_EXE;
            rsp_data  <= alu_result;
            rsp_ovf   <= alu_ovf;
            last      <= grant[1] ? REQ_ADDR : REQ_EXE;
            if (grant[0] && req0_set_cc) begin
                cc_zf <= (alu_result == '0);
                cc_sf <= alu_result[W-1];
                cc_of <= alu_ovf;
            end
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, directed
// multi-cycle sequences and a randomized run against a reference model.
module tb_alu_arbiter;

    localparam int W = 64;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [1:0]   req0_ctrl = 2'b00;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic         req0_set_cc = 1'b0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [1:0]   req1_ctrl = 2'b00;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_id;
    logic [W-1:0] rsp_data;
    logic         rsp_ovf;
    logic         cc_zf;
    logic         cc_sf;
    logic         cc_of;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_ctrl   (req0_ctrl),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_set_cc (req0_set_cc),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_ctrl   (req1_ctrl),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_ovf     (rsp_ovf),
        .cc_zf       (cc_zf),
        .cc_sf       (cc_sf),
        .cc_of       (cc_of)
    );

    typedef struct {
        logic [1:0]  ctrl;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] data;
        logic        ovf;
        logic        zf;
        logic        sf;
        logic        of;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_cc(input string name, input logic zf,
                          input logic sf, input logic of);
        chk({name, "_zf"}, {63'd0, cc_zf}, {63'd0, zf});
        chk({name, "_sf"}, {63'd0, cc_sf}, {63'd0, sf});
        chk({name, "_of"}, {63'd0, cc_of}, {63'd0, of});
    endtask

    // Reference ALU from signed integer arithmetic on a wider range.
    task automatic ref_op(input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] r,
                          output logic ovf);
        logic signed [64:0] sa, sb, s, smax, smin;
        sa = $signed({a[63], a});
        sb = $signed({b[63], b});
        smax = $signed({1'b0, MAXV});
        smin = $signed({1'b1, MINV});
        s = '0;
        ovf = 1'b0;
        case (op)
            2'b00: s = sa + sb;
            2'b01: s = sa - sb;
            2'b10: s = $signed({1'b0, a & b});
            default: s = $signed({1'b0, a ^ b});
        endcase
        if (op == 2'b00 || op == 2'b01)
            ovf = (s > smax) || (s < smin);
        r = s[63:0];
    endtask

    function automatic logic [63:0] pick();
        logic [63:0] v;
        case ($urandom_range(0, 6))
            0: v = 64'd0;
            1: v = 64'd1;
            2: v = ONES;
            3: v = MINV;
            4: v = MAXV;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    logic        m_valid, m_id, m_ovf, m_zf, m_sf, m_of, m_last;
    logic [63:0] m_data;
    logic        pend0, pend1;

    initial begin
        tbl[0] = '{2'b00, 64'd5, ONES - 64'd4, 64'd0, 0, 1, 0, 0};
        tbl[1] = '{2'b01, MINV, 64'd1, MAXV, 1, 0, 0, 1};
        tbl[2] = '{2'b00, MAXV, 64'd1, MINV, 1, 0, 1, 1};
        tbl[3] = '{2'b10, 64'hF0, 64'h3C, 64'h30, 0, 0, 0, 0};
        tbl[4] = '{2'b11, ONES, 64'd0, ONES, 0, 0, 1, 0};
        tbl[5] = '{2'b01, 64'd3, 64'd5, ONES - 64'd1, 0, 0, 1, 0};
        tbl[6] = '{2'b00, ONES, ONES, ONES - 64'd1, 0, 0, 1, 0};
        tbl[7] = '{2'b01, 64'd0, MINV, MINV, 1, 0, 1, 1};

        // Reset for two cycles, release at a falling edge.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_r0", {63'd0, req0_ready}, 64'd0);
        chk("rst_r1", {63'd0, req1_ready}, 64'd0);
        chk_cc("rst", 1'b1, 1'b0, 1'b0);

        // Single port-0 ops with CC update.
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req0_valid  = 1'b1;
            req0_set_cc = 1'b1;
            req0_ctrl   = tbl[i].ctrl;
            req0_a      = tbl[i].a;
            req0_b      = tbl[i].b;
            #1;
            chk($sformatf("tbl%0d_ready", i),
                {63'd0, req0_ready}, 64'd1);
            @(negedge clk);
            req0_valid = 1'b0;
            #1;
            chk($sformatf("tbl%0d_valid", i),
                {63'd0, rsp_valid}, 64'd1);
            chk($sformatf("tbl%0d_id", i), {63'd0, rsp_id}, 64'd0);
            chk($sformatf("tbl%0d_data", i), rsp_data, tbl[i].data);
            chk($sformatf("tbl%0d_ovf", i),
                {63'd0, rsp_ovf}, {63'd0, tbl[i].ovf});
            chk_cc($sformatf("tbl%0d", i),
                   tbl[i].zf, tbl[i].sf, tbl[i].of);
        end

        // Port-1 result leaves CC alone (zf0 sf1 of1 from tbl7).
        req1_valid = 1'b1;
        req1_ctrl  = 2'b11;
        req1_a     = 64'd7;
        req1_b     = 64'd7;
        #1;
        chk("p1_ready", {63'd0, req1_ready}, 64'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        chk("p1_data", rsp_data, 64'd0);
        chk("p1_id", {63'd0, rsp_id}, 64'd1);
        chk_cc("p1", 1'b0, 1'b1, 1'b1);

        // Contention: strict alternation starting with port 0.
        req0_valid  = 1'b1;
        req0_set_cc = 1'b1;
        req0_ctrl   = 2'b10;
        req0_a      = 64'hF0;
        req0_b      = 64'h3C;
        req1_valid  = 1'b1;
        req1_ctrl   = 2'b00;
        req1_a      = 64'd8;
        req1_b      = 64'd16;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("ct%0d_r0", i),
                {63'd0, req0_ready}, {63'd0, (i % 2 == 0)});
            chk($sformatf("ct%0d_r1", i),
                {63'd0, req1_ready}, {63'd0, (i % 2 == 1)});
            @(negedge clk);
            #1;
            chk($sformatf("ct%0d_id", i),
                {63'd0, rsp_id}, (i % 2 == 0) ? 64'd0 : 64'd1);
            chk($sformatf("ct%0d_data", i), rsp_data,
                (i % 2 == 0) ? 64'h30 : 64'd24);
            chk_cc($sformatf("ct%0d", i), 1'b0, 1'b0, 1'b0);
        end

        // Backpressure: buffer holds 24 from port 1.
        rsp_ready   = 1'b0;
        req0_set_cc = 1'b0;
        req0_ctrl   = 2'b00;
        req0_a      = 64'd1;
        req0_b      = 64'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d_r0", i), {63'd0, req0_ready}, 64'd0);
            chk($sformatf("bp%0d_r1", i), {63'd0, req1_ready}, 64'd0);
            @(negedge clk);
            #1;
            chk($sformatf("bp%0d_valid", i),
                {63'd0, rsp_valid}, 64'd1);
            chk($sformatf("bp%0d_data", i), rsp_data, 64'd24);
        end

        // Drain and accept in the same cycle; last was port 1.
        rsp_ready = 1'b1;
        #1;
        chk("dr_r0", {63'd0, req0_ready}, 64'd1);
        chk("dr_r1", {63'd0, req1_ready}, 64'd0);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        chk("dr_valid", {63'd0, rsp_valid}, 64'd1);
        chk("dr_data", rsp_data, 64'd3);
        chk("dr_id", {63'd0, rsp_id}, 64'd0);
        chk_cc("dr", 1'b0, 1'b0, 1'b0);

        // Reset while a result is buffered and a request is pending.
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        rst_n      = 1'b1;
        #1;
        chk("mr_valid", {63'd0, rsp_valid}, 64'd0);
        chk("mr_data", rsp_data, 64'd0);
        chk_cc("mr", 1'b1, 1'b0, 1'b0);

        // Randomized run against the reference model.
        m_valid = 1'b0;
        m_id    = 1'b0;
        m_data  = '0;
        m_ovf   = 1'b0;
        m_zf    = 1'b1;
        m_sf    = 1'b0;
        m_of    = 1'b0;
        m_last  = 1'b1;
        pend0   = 1'b0;
        pend1   = 1'b0;
        for (int c = 0; c < 600; c++) begin
            int          win;
            logic        can;
            logic [63:0] r;
            logic        ov;
            @(negedge clk);
            chk("rnd_valid", {63'd0, rsp_valid}, {63'd0, m_valid});
            if (m_valid) begin
                chk("rnd_id", {63'd0, rsp_id}, {63'd0, m_id});
                chk("rnd_data", rsp_data, m_data);
                chk("rnd_ovf", {63'd0, rsp_ovf}, {63'd0, m_ovf});
            end
            chk_cc("rnd", m_zf, m_sf, m_of);
            if (!pend0) begin
                req0_valid  = ($urandom_range(0, 2) != 0);
                req0_ctrl   = 2'($urandom_range(0, 3));
                req0_a      = pick();
                req0_b      = pick();
                req0_set_cc = $urandom_range(0, 1) == 1;
            end
            if (!pend1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_ctrl  = 2'($urandom_range(0, 3));
                req1_a     = pick();
                req1_b     = pick();
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            can = !m_valid || rsp_ready;
            win = -1;
            if (can) begin
                if (req0_valid && req1_valid) win = m_last ? 0 : 1;
                else if (req0_valid) win = 0;
                else if (req1_valid) win = 1;
            end
            chk("rnd_r0", {63'd0, req0_ready}, {63'd0, win == 0});
            chk("rnd_r1", {63'd0, req1_ready}, {63'd0, win == 1});
            if (win == 0) begin
                ref_op(req0_ctrl, req0_a, req0_b, r, ov);
                if (req0_set_cc) begin
                    m_zf = (r == 64'd0);
                    m_sf = r[63];
                    m_of = ov;
                end
            end else if (win == 1) begin
                ref_op(req1_ctrl, req1_a, req1_b, r, ov);
            end else begin
                r  = '0;
                ov = 1'b0;
            end
            if (win >= 0) begin
                m_valid = 1'b1;
                m_id    = (win == 1);
                m_last  = (win == 1);
                m_data  = r;
                m_ovf   = ov;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
            pend0 = req0_valid && (win != 0);
            pend1 = req1_valid && (win != 1);
        end

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
